// File: rtl/core_pkg.sv
// Shared definitions for the instruction-fetch control slice.
//   if_state_e   : fetch controller state encoding
//   redir_kind_e : kind of a redirect request (branch or trap)
//   redir_t      : redirect kind + raw (unaligned) target address
//   align_word / is_misaligned : word-alignment helpers for redirect targets
package core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_MISS  = 2'd2,
    ST_PEND  = 2'd3
  } if_state_e;

  typedef enum logic {
    RK_BRANCH = 1'b0,
    RK_TRAP   = 1'b1
  } redir_kind_e;

  typedef struct packed {
    redir_kind_e kind;
    logic [31:0] addr;
  } redir_t;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [31:0] a);
    return |a[1:0];
  endfunction

endpackage

// File: rtl/core_if_ctrl_if.sv
// Handshake bundle between the fetch controller and its neighbours
// (L1I, decode, execute, trap unit).
//   slave  : fetch controller side (receives requests, drives IF strobes)
//   master : environment side (drives requests, observes IF strobes)
interface core_if_ctrl_if;
  logic        l1i_ack;
  logic        dec_stall;
  logic        ex_br_val;
  logic [31:0] ex_br_addr;
  logic        trap_val;
  logic [31:0] trap_addr;
  logic        if_enb;
  logic        if_kill;
  logic        if_mux_trn_s;
  logic [31:0] if_addr_mux_trn;
  logic        if_misalign;

  modport master (
    output l1i_ack, dec_stall, ex_br_val, ex_br_addr, trap_val, trap_addr,
    input  if_enb, if_kill, if_mux_trn_s, if_addr_mux_trn, if_misalign
  );

  modport slave (
    input  l1i_ack, dec_stall, ex_br_val, ex_br_addr, trap_val, trap_addr,
    output if_enb, if_kill, if_mux_trn_s, if_addr_mux_trn, if_misalign
  );
endinterface

// File: rtl/core_if_redir_sel.sv
// Combinational redirect selection.
//   trap_val/trap_addr, ex_br_val/ex_br_addr : incoming redirect requests
//   use_pend   : controller is in PEND, apply the (merged) pending redirect
//   pend_i     : current pending redirect register
//   new_val_o  : some redirect requested this cycle
//   new_o      : requested redirect after trap-over-branch priority
//   merged_o   : pending register after folding in this cycle's request
//   app_addr_o : word-aligned address of the redirect being applied
//   app_mis_o  : applied redirect address had non-zero low bits
module core_if_redir_sel
  import core_pkg::*;
(
  input  logic        trap_val,
  input  logic [31:0] trap_addr,
  input  logic        ex_br_val,
  input  logic [31:0] ex_br_addr,
  input  logic        use_pend,
  input  redir_t      pend_i,
  output logic        new_val_o,
  output redir_t      new_o,
  output redir_t      merged_o,
  output logic [31:0] app_addr_o,
  output logic        app_mis_o
);

  redir_t app;

  always_comb begin
    new_val_o  = trap_val | ex_br_val;
    new_o.kind = trap_val ? RK_TRAP : RK_BRANCH;
    new_o.addr = trap_val ? trap_addr : ex_br_addr;

    // A trap always replaces the pending entry; a branch may only replace
    // another branch, never a pending trap.
    merged_o = pend_i;
    if (new_val_o && ((new_o.kind == RK_TRAP) || (pend_i.kind == RK_BRANCH))) begin
      merged_o = new_o;
    end

    app        = use_pend ? merged_o : new_o;
    app_addr_o = align_word(app.addr);
    app_mis_o  = is_misaligned(app.addr);
  end

endmodule

// File: rtl/core_if_ctrl.sv
// Instruction-fetch control: sequences PC advance, IF/DEC load and kill, and
// applies branch/trap redirects, deferring a redirect that arrives during an
// L1I miss until the outstanding word returns.
//   clk, rst_n      : core clock, asynchronous active-low reset
//   bus (slave)     : L1I ack, decode stall, branch/trap requests in;
//                     if_enb, if_kill, if_mux_trn_s, if_addr_mux_trn,
//                     if_misalign out (all combinational)
//   fetch_stall_cnt : saturating count of FETCH/MISS/PEND cycles without if_enb
`ifndef PC_START
`define PC_START 32'h0000_0000
`endif

module core_if_ctrl
  import core_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16,
  parameter logic [31:0] PC_START    = `PC_START
)
(
  input  logic                   clk,
  input  logic                   rst_n,
  core_if_ctrl_if.slave          bus,
  output logic [STALL_CNT_W-1:0] fetch_stall_cnt
);

  // Reset PC is consumed by the PC register elsewhere; only sanity-checked here.
  if (PC_START[1:0] != 2'b00) begin : g_bad_pc_start
    $error("PC_START must be word aligned");
  end

  if_state_e              state_q, state_d;
  redir_t                 pend_q, pend_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  logic        new_val;
  redir_t      new_redir;
  redir_t      merged;
  logic [31:0] app_addr;
  logic        app_mis;

  logic        if_enb, if_kill, if_mux_trn_s, if_misalign;
  logic        take_word;

  core_if_redir_sel u_redir_sel (
    .trap_val   (bus.trap_val),
    .trap_addr  (bus.trap_addr),
    .ex_br_val  (bus.ex_br_val),
    .ex_br_addr (bus.ex_br_addr),
    .use_pend   (state_q == ST_PEND),
    .pend_i     (pend_q),
    .new_val_o  (new_val),
    .new_o      (new_redir),
    .merged_o   (merged),
    .app_addr_o (app_addr),
    .app_mis_o  (app_mis)
  );

  assign take_word = bus.l1i_ack & ~bus.dec_stall;

  // State register, pending register and stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and pending-register update.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        // A redirect in FETCH is applied immediately, so the state is kept.
        if (!new_val && !bus.l1i_ack) state_d = ST_MISS;
      end
      ST_MISS: begin
        if (new_val) begin
          pend_d  = new_redir;
          state_d = ST_PEND;
        end else if (bus.l1i_ack) begin
          state_d = ST_FETCH;
        end
      end
      ST_PEND: begin
        pend_d = merged;
        if (bus.l1i_ack) begin
          pend_d  = '0;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output strobes.
  always_comb begin
    if_enb       = 1'b0;
    if_kill      = 1'b0;
    if_mux_trn_s = 1'b0;
    if_misalign  = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        if (new_val) begin
          if_enb       = 1'b1;
          if_kill      = 1'b1;
          if_mux_trn_s = 1'b1;
          if_misalign  = app_mis;
        end else begin
          if_enb = take_word;
        end
      end
      ST_MISS: begin
        if (!new_val) if_enb = take_word;
      end
      ST_PEND: begin
        // The returning word belongs to the old stream and is discarded.
        if (bus.l1i_ack) begin
          if_enb       = 1'b1;
          if_kill      = 1'b1;
          if_mux_trn_s = 1'b1;
          if_misalign  = app_mis;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q != ST_IDLE) && !if_enb && (cnt_q != '1)) begin
      cnt_d = cnt_q + STALL_CNT_W'(1);
    end
  end

  assign bus.if_enb          = if_enb;
  assign bus.if_kill         = if_kill;
  assign bus.if_mux_trn_s    = if_mux_trn_s;
  assign bus.if_addr_mux_trn = if_mux_trn_s ? app_addr : '0;
  assign bus.if_misalign     = if_misalign;
  assign fetch_stall_cnt     = cnt_q;

endmodule

// File: tb/tb_core_if_ctrl.sv
module tb_core_if_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cnt;
  int          n_checks = 0;
  int          n_fail = 0;

  core_if_ctrl_if bus ();

  core_if_ctrl #(.STALL_CNT_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .fetch_stall_cnt (cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic strobes(input string tag, input logic enb, input logic kill,
                         input logic mux, input logic [31:0] addr, input logic mis);
    check({tag, ".enb"},  {31'b0, bus.if_enb},       {31'b0, enb});
    check({tag, ".kill"}, {31'b0, bus.if_kill},      {31'b0, kill});
    check({tag, ".mux"},  {31'b0, bus.if_mux_trn_s}, {31'b0, mux});
    check({tag, ".addr"}, bus.if_addr_mux_trn,       addr);
    check({tag, ".mis"},  {31'b0, bus.if_misalign},  {31'b0, mis});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ack, input logic stall, input logic tv, input logic [31:0] ta,
                       input logic bv, input logic [31:0] ba);
    bus.l1i_ack    = ack;
    bus.dec_stall  = stall;
    bus.trap_val   = tv;
    bus.trap_addr  = ta;
    bus.ex_br_val  = bv;
    bus.ex_br_addr = ba;
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h20);
    // Reset: everything quiet despite active requests.
    strobes("rst", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("rst.cnt", {16'b0, cnt}, 32'h0);
    tick();
    tick();

    // Reset release with ack=1, stall=0: IDLE cycle then if_enb every cycle.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    rst_n = 1'b1;
    #1;
    strobes("idle", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(); check("fetch1.enb", {31'b0, bus.if_enb}, 32'h1);
    tick(); check("fetch2.enb", {31'b0, bus.if_enb}, 32'h1);
    tick(); check("fetch3.enb", {31'b0, bus.if_enb}, 32'h1);
    check("fetch.cnt", {16'b0, cnt}, 32'h0);

    // Miss: three cycles without ack, then ack.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("miss0.enb", {31'b0, bus.if_enb}, 32'h0);
    tick(); check("miss1.enb", {31'b0, bus.if_enb}, 32'h0);
    tick(); check("miss2.enb", {31'b0, bus.if_enb}, 32'h0);
    tick(); drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    strobes("miss_ack", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("miss.cnt", {16'b0, cnt}, 32'h3);

    // FETCH with ack and decode stall: hold, no advance.
    tick(); drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("stall.enb", {31'b0, bus.if_enb}, 32'h0);
    tick(); drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("unstall.enb", {31'b0, bus.if_enb}, 32'h1);
    check("stall.cnt", {16'b0, cnt}, 32'h4);

    // FETCH: trap and branch together, ack low -> immediate trap redirect.
    tick(); drive(1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h200);
    strobes("fetch_trap", 1'b1, 1'b1, 1'b1, 32'h100, 1'b0);
    tick(); drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    strobes("post_trap", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    // FETCH: misaligned branch 0x1003 -> 0x1000 with one-cycle misalign pulse.
    tick(); drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1003);
    strobes("fetch_mis", 1'b1, 1'b1, 1'b1, 32'h1000, 1'b1);
    tick(); drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    strobes("post_mis", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    // MISS: branch 0x40, then trap 0x80, then branch 0xC0, then ack.
    tick(); drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);   // FETCH -> MISS, cnt 5
    tick(); drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40);  // MISS latch, cnt 6
    strobes("miss_br", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(); drive(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);  // PEND, cnt 7
    strobes("pend_trap", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(); drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC0);  // PEND, cnt 8
    strobes("pend_br", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(); drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    strobes("pend_apply", 1'b1, 1'b1, 1'b1, 32'h80, 1'b0);
    check("pend.cnt", {16'b0, cnt}, 32'h8);
    tick(); drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    strobes("post_pend", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    // PEND branch overwritten by a misaligned branch arriving with the ack.
    tick(); drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);   // cnt 9
    tick(); drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40);  // cnt 10
    tick(); drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1003);
    strobes("pend_same", 1'b1, 1'b1, 1'b1, 32'h1000, 1'b1);
    tick(); drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    strobes("post_same", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("same.cnt", {16'b0, cnt}, 32'hA);

    // Fresh reset, then a very long miss: counter saturates at 0xFFFF.
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("rst2.cnt", {16'b0, cnt}, 32'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 70000; i++) tick();
    check("sat.cnt", {16'b0, cnt}, 32'hFFFF);
    tick();
    check("sat_hold.cnt", {16'b0, cnt}, 32'hFFFF);

    // Enter PEND, prove the pending redirect is live, then reset mid-PEND.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300);
    tick(); drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    strobes("pend_live", 1'b1, 1'b1, 1'b1, 32'h300, 1'b0);
    rst_n = 1'b0;
    #1;
    strobes("rst_pend", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("rst_pend.cnt", {16'b0, cnt}, 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    strobes("idle2", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    strobes("dropped", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
